// File: rtl/fpnew_pkg_snax.sv
// Shared FP types for the SNAX FPU slice: formats, the classifier record,
// and the FCLASS mask bit positions.
package fpnew_pkg_snax;

  typedef enum logic [2:0] {
    FP32    = 3'd0,
    FP64    = 3'd1,
    FP16    = 3'd2,
    FP8     = 3'd3,
    FP16ALT = 3'd4
  } fp_format_e;

  typedef struct packed {
    logic is_normal;
    logic is_subnormal;
    logic is_zero;
    logic is_inf;
    logic is_nan;
    logic is_signalling;
    logic is_quiet;
    logic is_boxed;
  } fp_info_t;

  localparam int unsigned CLASS_BITS = 10;

  typedef enum logic [3:0] {
    CLS_NEG_INF     = 4'd0,
    CLS_NEG_NORM    = 4'd1,
    CLS_NEG_SUBNORM = 4'd2,
    CLS_NEG_ZERO    = 4'd3,
    CLS_POS_ZERO    = 4'd4,
    CLS_POS_SUBNORM = 4'd5,
    CLS_POS_NORM    = 4'd6,
    CLS_POS_INF     = 4'd7,
    CLS_SNAN        = 4'd8,
    CLS_QNAN        = 4'd9
  } classmask_e;

  function automatic int unsigned fp_width(fp_format_e fmt);
    case (fmt)
      FP64:          return 64;
      FP16, FP16ALT: return 16;
      FP8:           return 8;
      default:       return 32;
    endcase
  endfunction

endpackage

// File: rtl/fpnew_pipe_reg_snax.sv
// One valid/ready register stage with flush; ready looks through to the
// successor so a full chain still moves one entry per cycle.
module fpnew_pipe_reg_snax #(
  parameter int unsigned DataWidth = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 flush_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [DataWidth-1:0] in_data_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [DataWidth-1:0] out_data_o
);

  logic                 valid_q, valid_d;
  logic [DataWidth-1:0] data_q, data_d;

  assign in_ready_o = ~valid_q | out_ready_i;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (in_ready_o) begin
      valid_d = in_valid_i;
      if (in_valid_i) data_d = in_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;

endmodule

// File: rtl/fpnew_class_pipe_snax.sv
// FCLASS mask generation from a classifier record, followed by a
// configurable valid/ready register pipeline carrying an opaque tag.
module fpnew_class_pipe_snax import fpnew_pkg_snax::*; #(
  parameter fp_format_e  FpFormat    = fpnew_pkg_snax::fp_format_e'(0),
  parameter int unsigned WIDTH       = fpnew_pkg_snax::fp_width(FpFormat),
  parameter int unsigned NumPipeRegs = 1,
  parameter int unsigned TagWidth    = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [WIDTH-1:0]      operand_i,
  input  fp_info_t              info_i,
  input  logic [TagWidth-1:0]   tag_i,
  input  logic                  flush_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [CLASS_BITS-1:0] class_o,
  output logic [TagWidth-1:0]   tag_o,
  output logic                  busy_o
);

  localparam int unsigned PayloadW = CLASS_BITS + TagWidth;

  logic                  sign;
  logic [CLASS_BITS-1:0] class_mask;

  assign sign = operand_i[WIDTH-1];

  // Unboxed operands arrive flagged as quiet NaN, so no extra term is needed.
  always_comb begin
    class_mask                  = '0;
    class_mask[CLS_NEG_INF]     = sign  & info_i.is_inf;
    class_mask[CLS_NEG_NORM]    = sign  & info_i.is_normal;
    class_mask[CLS_NEG_SUBNORM] = sign  & info_i.is_subnormal;
    class_mask[CLS_NEG_ZERO]    = sign  & info_i.is_zero;
    class_mask[CLS_POS_ZERO]    = ~sign & info_i.is_zero;
    class_mask[CLS_POS_SUBNORM] = ~sign & info_i.is_subnormal;
    class_mask[CLS_POS_NORM]    = ~sign & info_i.is_normal;
    class_mask[CLS_POS_INF]     = ~sign & info_i.is_inf;
    class_mask[CLS_SNAN]        = info_i.is_signalling;
    class_mask[CLS_QNAN]        = info_i.is_quiet;
  end

  logic unused_ok;
  assign unused_ok = ^{operand_i[WIDTH-2:0], info_i.is_nan, info_i.is_boxed,
                       clk_i, rst_i};

  if (NumPipeRegs == 0) begin : g_comb
    assign out_valid_o = in_valid_i & ~flush_i;
    assign in_ready_o  = out_ready_i & ~flush_i;
    assign class_o     = class_mask;
    assign tag_o       = tag_i;
    assign busy_o      = 1'b0;
  end else begin : g_pipe
    logic [NumPipeRegs:0] valid;
    logic [NumPipeRegs:0] ready;
    logic [PayloadW-1:0]  data [NumPipeRegs+1];

    assign valid[0]           = in_valid_i & ~flush_i;
    assign data[0]            = {class_mask, tag_i};
    assign ready[NumPipeRegs] = out_ready_i;

    for (genvar k = 0; k < NumPipeRegs; k++) begin : g_stage
      fpnew_pipe_reg_snax #(
        .DataWidth(PayloadW)
      ) i_stage (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .flush_i    (flush_i),
        .in_valid_i (valid[k]),
        .in_ready_o (ready[k]),
        .in_data_i  (data[k]),
        .out_valid_o(valid[k+1]),
        .out_ready_i(ready[k+1]),
        .out_data_o (data[k+1])
      );
    end

    assign in_ready_o       = ready[0] & ~flush_i;
    assign out_valid_o      = valid[NumPipeRegs];
    assign {class_o, tag_o} = data[NumPipeRegs];
    assign busy_o           = |valid[NumPipeRegs:1];
  end

endmodule

// File: tb/tb_fpnew_class_pipe_snax.sv
// Scoreboard bench for the FCLASS pipeline at depths 1, 2 and 0.
module tb_fpnew_class_pipe_snax;
  import fpnew_pkg_snax::*;

  typedef struct {
    logic [9:0] cls;
    logic [3:0] tag;
    int         cyc;
  } exp_t;

  localparam logic [31:0] OPS [7] = '{32'hFF800000, 32'h00000000, 32'h80000001,
                                      32'h3F800000, 32'h7F800001, 32'h7FC00000,
                                      32'h80000000};
  localparam logic [9:0]  EXP [7] = '{10'h001, 10'h010, 10'h004, 10'h040,
                                      10'h100, 10'h200, 10'h200};

  logic clk = 0;
  logic rst = 1;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  exp_t q_a[$];
  exp_t q_b[$];

  // per-DUT signals: a = depth 1, b = depth 2, c = depth 0
  logic in_valid_a = 0, in_valid_b = 0, in_valid_c = 0;
  logic in_ready_a, in_ready_b, in_ready_c;
  logic [31:0] op_a = '0, op_b = '0, op_c = '0;
  fp_info_t info_a = '0, info_b = '0, info_c = '0;
  logic [3:0] tag_a = '0, tag_b = '0, tag_c = '0;
  logic flush_a = 0, flush_b = 0, flush_c = 0;
  logic out_valid_a, out_valid_b, out_valid_c;
  logic out_ready_a = 1, out_ready_b = 1, out_ready_c = 1;
  logic [9:0] class_a, class_b, class_c;
  logic [3:0] tag_o_a, tag_o_b, tag_o_c;
  logic busy_a, busy_b, busy_c;

  fpnew_class_pipe_snax #(.FpFormat(FP32), .NumPipeRegs(1), .TagWidth(4)) dut_a (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid_a), .in_ready_o(in_ready_a),
    .operand_i(op_a), .info_i(info_a), .tag_i(tag_a), .flush_i(flush_a),
    .out_valid_o(out_valid_a), .out_ready_i(out_ready_a), .class_o(class_a),
    .tag_o(tag_o_a), .busy_o(busy_a));

  fpnew_class_pipe_snax #(.FpFormat(FP32), .NumPipeRegs(2), .TagWidth(4)) dut_b (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid_b), .in_ready_o(in_ready_b),
    .operand_i(op_b), .info_i(info_b), .tag_i(tag_b), .flush_i(flush_b),
    .out_valid_o(out_valid_b), .out_ready_i(out_ready_b), .class_o(class_b),
    .tag_o(tag_o_b), .busy_o(busy_b));

  fpnew_class_pipe_snax #(.FpFormat(FP32), .NumPipeRegs(0), .TagWidth(4)) dut_c (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid_c), .in_ready_o(in_ready_c),
    .operand_i(op_c), .info_i(info_c), .tag_i(tag_c), .flush_i(flush_c),
    .out_valid_o(out_valid_c), .out_ready_i(out_ready_c), .class_o(class_c),
    .tag_o(tag_o_c), .busy_o(busy_c));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic fp_info_t info_of(input int k);
    fp_info_t i;
    i = '0;
    i.is_boxed = 1'b1;
    case (k)
      0: i.is_inf = 1'b1;
      1: i.is_zero = 1'b1;
      2: i.is_subnormal = 1'b1;
      3: i.is_normal = 1'b1;
      4: begin i.is_nan = 1'b1; i.is_signalling = 1'b1; end
      5: begin i.is_nan = 1'b1; i.is_quiet = 1'b1; end
      default: begin i.is_nan = 1'b1; i.is_quiet = 1'b1; i.is_boxed = 1'b0; end
    endcase
    return i;
  endfunction

  // Depth 1: result expected exactly one cycle after the input handshake.
  task automatic send_a(input int k, input logic [3:0] t);
    logic hs;
    op_a = OPS[k]; info_a = info_of(k); tag_a = t; in_valid_a = 1;
    q_a.push_back('{EXP[k], t, cyc + 1});
    @(negedge clk);
    hs = in_ready_a;
    chk("a_accept", {31'd0, hs}, 32'd1);
    @(posedge clk); #1;
    in_valid_a = 0;
  endtask

  task automatic send_b(input int k, input logic [3:0] t);
    logic hs;
    int n;
    hs = 0; n = 0;
    op_b = OPS[k]; info_b = info_of(k); tag_b = t; in_valid_b = 1;
    q_b.push_back('{EXP[k], t, 0});
    while (!hs && n < 20) begin
      @(negedge clk);
      hs = in_ready_b;
      @(posedge clk); #1;
      n++;
    end
    chk("b_accept", {31'd0, hs}, 32'd1);
    in_valid_b = 0;
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid_a && out_ready_a) begin
      if (q_a.size() == 0) chk("a_unexpected_out", {28'd0, tag_o_a}, 32'hFFFFFFFF);
      else begin
        exp_t e;
        e = q_a.pop_front();
        chk("a_class", {22'd0, class_a}, {22'd0, e.cls});
        chk("a_tag", {28'd0, tag_o_a}, {28'd0, e.tag});
        chk("a_latency_cycle", cyc, e.cyc);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && out_valid_b && out_ready_b) begin
      if (q_b.size() == 0) chk("b_unexpected_out", {28'd0, tag_o_b}, 32'hFFFFFFFF);
      else begin
        exp_t e;
        e = q_b.pop_front();
        chk("b_class", {22'd0, class_b}, {22'd0, e.cls});
        chk("b_tag", {28'd0, tag_o_b}, {28'd0, e.tag});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rst_a_out_valid", {31'd0, out_valid_a}, 32'd0);
    chk("rst_a_class", {22'd0, class_a}, 32'd0);
    chk("rst_a_tag", {28'd0, tag_o_a}, 32'd0);
    chk("rst_a_busy", {31'd0, busy_a}, 32'd0);
    chk("rst_a_in_ready", {31'd0, in_ready_a}, 32'd1);
    chk("rst_b_out_valid", {31'd0, out_valid_b}, 32'd0);
    chk("rst_b_in_ready", {31'd0, in_ready_b}, 32'd1);
    chk("rst_b_busy", {31'd0, busy_b}, 32'd0);
    @(posedge clk); #1;

    for (int k = 0; k < 7; k++) send_a(k, 4'(k + 1));
    repeat (3) @(posedge clk); #1;
    chk("a_drained", q_a.size(), 32'd0);

    // Backpressure: output stalled for 4 edges while 5 entries are offered.
    fork
      begin
        for (int t = 1; t <= 5; t++) send_b(t - 1, 4'(t));
      end
      begin
        out_ready_b = 0;
        for (int i = 0; i < 4; i++) begin
          @(negedge clk);
          if (i >= 2) begin
            chk("bp_in_ready_low", {31'd0, in_ready_b}, 32'd0);
            chk("bp_out_valid", {31'd0, out_valid_b}, 32'd1);
            chk("bp_tag_stable", {28'd0, tag_o_b}, 32'd1);
            chk("bp_class_stable", {22'd0, class_b}, 32'h001);
          end
        end
        @(posedge clk); #1;
        out_ready_b = 1;
      end
    join
    for (int i = 0; i < 30 && q_b.size() != 0; i++) @(posedge clk);
    #1;
    chk("bp_drained", q_b.size(), 32'd0);
    @(negedge clk);
    chk("bp_busy_idle", {31'd0, busy_b}, 32'd0);
    @(posedge clk); #1;

    // Flush with two entries in flight and a simultaneous input offer.
    out_ready_b = 0;
    send_b(5, 4'd6);
    send_b(6, 4'd7);
    chk("fl_busy_before", {31'd0, busy_b}, 32'd1);
    op_b = OPS[3]; info_b = info_of(3); tag_b = 4'd8; in_valid_b = 1; flush_b = 1;
    @(negedge clk);
    chk("fl_in_ready", {31'd0, in_ready_b}, 32'd0);
    @(posedge clk); #1;
    flush_b = 0; in_valid_b = 0;
    q_b.delete();
    @(negedge clk);
    chk("fl_out_valid", {31'd0, out_valid_b}, 32'd0);
    chk("fl_busy", {31'd0, busy_b}, 32'd0);
    out_ready_b = 1;
    repeat (3) @(negedge clk);
    chk("fl_dropped_not_emitted", {31'd0, out_valid_b}, 32'd0);
    @(posedge clk); #1;

    // Reset with a full pipeline.
    out_ready_b = 0;
    send_b(3, 4'd9);
    send_b(0, 4'd10);
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    q_b.delete();
    @(negedge clk);
    chk("mrst_out_valid", {31'd0, out_valid_b}, 32'd0);
    chk("mrst_class", {22'd0, class_b}, 32'd0);
    chk("mrst_tag", {28'd0, tag_o_b}, 32'd0);
    chk("mrst_in_ready", {31'd0, in_ready_b}, 32'd1);
    @(posedge clk); #1;
    out_ready_b = 1;
    send_b(3, 4'd11);
    for (int i = 0; i < 10 && q_b.size() != 0; i++) @(posedge clk);
    #1;
    chk("post_rst_drained", q_b.size(), 32'd0);

    // Depth 0: combinational path.
    op_c = OPS[3]; info_c = info_of(3); tag_c = 4'd5; in_valid_c = 1; out_ready_c = 1;
    #2;
    chk("c_class", {22'd0, class_c}, 32'h040);
    chk("c_tag", {28'd0, tag_o_c}, 32'd5);
    chk("c_out_valid", {31'd0, out_valid_c}, 32'd1);
    chk("c_in_ready_hi", {31'd0, in_ready_c}, 32'd1);
    out_ready_c = 0;
    #1;
    chk("c_in_ready_lo", {31'd0, in_ready_c}, 32'd0);
    flush_c = 1;
    #1;
    chk("c_flush_out_valid", {31'd0, out_valid_c}, 32'd0);
    chk("c_busy", {31'd0, busy_c}, 32'd0);
    flush_c = 0; in_valid_c = 0;

    @(posedge clk); #1;
    chk("end_q_a_empty", q_a.size(), 32'd0);
    chk("end_q_b_empty", q_b.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
